// File: rtl/match_timestamp_capture.sv
// -----------------------------------------------------------------------------
// match_timestamp_capture
//
// Free-running nibble-cascade up-counter. The block captures the counter value
// on every match strobe and queues it in a small first-word-fall-through FIFO.
// A consumer drains the FIFO through a valid/ready handshake.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active low (has priority over clear)
//   en        in   count enable; the counter advances on cycles where en=1
//   match     in   match strobe; captures the pre-edge count
//   clear     in   synchronous soft clear; same effect as reset
//   count     out  current counter value
//   ts_data   out  head-of-FIFO timestamp (zero while the FIFO is empty)
//   ts_valid  out  FIFO non-empty
//   ts_ready  in   consumer accepts the head entry
//   level     out  FIFO occupancy, 0..DEPTH
//   overflow  out  sticky; set when a capture is dropped because the FIFO is full
// -----------------------------------------------------------------------------
module match_timestamp_capture #(
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              match,
    input  logic              clear,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int NIBS = CNT_W / 4;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_LVL  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR = (ADDR_W)'(1);

    // ------------------------------------------------------------------
    // Counter: nibble k steps when en is high and every lower nibble is 0xF.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [NIBS-1:0]  carry;

    assign carry[0] = en;

    generate
        for (genvar gi = 1; gi < NIBS; gi++) begin : g_carry
            assign carry[gi] = carry[gi-1] & (count_q[(gi-1)*4 +: 4] == 4'hF);
        end
        for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
            assign count_d[gi*4 +: 4] = carry[gi] ? (count_q[gi*4 +: 4] + 4'd1)
                                                  : count_q[gi*4 +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;

    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    assign full     = (level_q == FULL_LVL);
    assign pop      = valid_q & ts_ready & ~clear;
    assign push_req = match & ~clear;
    // A simultaneous pop frees the slot being written, so pushing into a full
    // FIFO is legal in that cycle (the write lands where the old head was).
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + ONE_LVL;
            2'b01:   level_d = level_q - ONE_LVL;
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; stale words are never exposed because
    // ts_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= count_q;
        end
    end

    assign count    = count_q;
    assign ts_valid = valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign ts_data  = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_match_timestamp_capture.sv
module tb_match_timestamp_capture;

    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              match;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  ts_data;
    logic              ts_valid;
    logic              ts_ready;
    logic [ADDR_W:0]   level;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    match_timestamp_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .match    (match),
        .clear    (clear),
        .count    (count),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: integer counter, queue of timestamps, sticky flag.
    // ------------------------------------------------------------------
    int          m_cnt = 0;
    int          m_q[$];
    bit          m_ovf = 0;
    bit          m_live = 0;

    always @(posedge clk) begin
        bit pop_now;
        if (!rst_n || clear) begin
            m_cnt = 0;
            m_q.delete();
            m_ovf = 0;
            m_live = 1;
        end else if (m_live) begin
            pop_now = (m_q.size() > 0) && ts_ready;
            if (match && m_q.size() == DEPTH && !pop_now) m_ovf = 1;
            if (pop_now) void'(m_q.pop_front());
            if (match && m_q.size() < DEPTH) m_q.push_back(m_cnt);
            if (en) m_cnt = (m_cnt + 1) % 65536;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_count",    32'(count),    32'(m_cnt));
            chk("m_valid",    32'(ts_valid), 32'(m_q.size() > 0));
            chk("m_level",    32'(level),    32'(m_q.size()));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_ts_data",  32'(ts_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic drain_expect(input string name, input int exp[4]);
        en = 1'b0;
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_valid%0d", name, i), 32'(ts_valid), 32'd1);
            chk($sformatf("%s_data%0d", name, i), 32'(ts_data), 32'(exp[i]));
            $display("drain %s[%0d]: ts_data=%0d", name, i, ts_data);
            tick(1);
        end
        ts_ready = 1'b0;
        chk({name, "_empty"}, 32'(ts_valid), 32'd0);
    endtask

    // Leaves 2 entries stored and overflow set.
    task automatic setup_two_ovf();
        do_clear();
        en = 1'b1;
        match = 1'b1;
        tick(6);
        match = 1'b0;
        ts_ready = 1'b1;
        tick(2);
        ts_ready = 1'b0;
        chk("pre_level", 32'(level), 32'd2);
        chk("pre_ovf", 32'(overflow), 32'd1);
    endtask

    initial begin
        int e1[4];
        int e2[4];
        rst_n = 1'b0; en = 1'b0; match = 1'b0; clear = 1'b0; ts_ready = 1'b0;
        tick(2);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(ts_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(ts_data), 32'd0);
        $display("reset: count=%0d level=%0d", count, level);

        rst_n = 1'b1;
        en = 1'b1;
        tick(20);
        chk("cnt20", 32'(count), 32'h14);
        chk("cnt20_valid", 32'(ts_valid), 32'd0);
        $display("count after 20 enables: 0x%0h", count);

        // Nibble carry and full wrap.
        en = 1'b0;
        do_clear();
        en = 1'b1;
        tick(15);
        chk("cnt_0F", 32'(count), 32'h000F);
        tick(1);
        chk("cnt_10", 32'(count), 32'h0010);
        tick(65535 - 16);
        chk("cnt_FFFF", 32'(count), 32'hFFFF);
        tick(1);
        chk("cnt_wrap", 32'(count), 32'h0000);
        chk("wrap_ovf", 32'(overflow), 32'd0);
        $display("wrap: count=0x%0h", count);

        // Capture latency.
        do_clear();
        en = 1'b1;
        tick(5);
        match = 1'b1;
        tick(1);
        match = 1'b0;
        chk("lat_valid", 32'(ts_valid), 32'd1);
        chk("lat_data", 32'(ts_data), 32'd5);
        chk("lat_level", 32'(level), 32'd1);
        chk("lat_count", 32'(count), 32'd6);
        $display("capture: ts_data=%0d count=%0d", ts_data, count);
        ts_ready = 1'b1;
        tick(1);
        ts_ready = 1'b0;
        chk("lat_popped", 32'(ts_valid), 32'd0);

        // Full / overflow.
        do_clear();
        en = 1'b1;
        tick(10);
        match = 1'b1;
        tick(6);
        match = 1'b0;
        chk("full_level", 32'(level), 32'd4);
        chk("full_ovf", 32'(overflow), 32'd1);
        e1 = '{10, 11, 12, 13};
        drain_expect("ovf", e1);

        // Push and pop together while full.
        do_clear();
        en = 1'b1;
        tick(30);
        match = 1'b1;
        tick(4);
        match = 1'b0;
        tick(6);
        chk("pp_count", 32'(count), 32'd40);
        match = 1'b1;
        ts_ready = 1'b1;
        tick(1);
        match = 1'b0;
        ts_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        e2 = '{31, 32, 33, 40};
        drain_expect("pp", e2);

        // clear beats match/en/ts_ready.
        setup_two_ovf();
        clear = 1'b1; match = 1'b1; en = 1'b1; ts_ready = 1'b1;
        tick(1);
        clear = 1'b0; match = 1'b0; en = 1'b0; ts_ready = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(ts_valid), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        $display("clear: level=%0d overflow=%0d", level, overflow);

        // Reset mid-operation.
        setup_two_ovf();
        rst_n = 1'b0; match = 1'b1; en = 1'b1; ts_ready = 1'b1;
        tick(1);
        rst_n = 1'b1; match = 1'b0; en = 1'b0; ts_ready = 1'b0;
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_valid", 32'(ts_valid), 32'd0);
        chk("rst2_ovf", 32'(overflow), 32'd0);
        chk("rst2_count", 32'(count), 32'd0);
        $display("reset mid-op: level=%0d overflow=%0d", level, overflow);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
